// File: rtl/video_frame_measure.sv
// video_frame_measure
// Measures active pixels per line and active lines per frame from de_i/vs_i
// on the pixel clock, and commits the geometry at each frame boundary.
// Optional build macro FRAME_MEAS_STABLE_EN: only commit after STABLE_FRAMES
// consecutive frames with identical (width, height).
module video_frame_measure #(
    parameter int VS_POL        = 1,
    parameter int STABLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vs_i,
    input  logic        de_i,
    output logic [10:0] src_width,
    output logic [10:0] src_height,
    output logic        meas_valid,
    output logic        line_err,
    output logic        ovf
);
    localparam logic [10:0] CNT_MAX = 11'd2047;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        vs_n;
    logic        vs_r;
    logic        vs_r2;
    logic        de_r;
    logic        de_r2;
    logic        vs_edge;
    logic        de_fall;

    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;
    logic [10:0] w_first;
    logic        err_w;
    logic        ovf_w;
    // Set when a line was already in progress at the frame boundary; that
    // line is thrown away until its de falls.
    logic        drop_line;

    logic        line_end;
    logic [10:0] line_nx;
    logic [10:0] wf_nx;
    logic        err_nx;
    logic        ovf_nx;
    logic        frame_end;
    logic        frame_empty;
    logic        do_commit;

    assign vs_n = (VS_POL != 0) ? vs_i : ~vs_i;

    // Two-stage input registers for sync and data enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vs_r  <= 1'b0;
            vs_r2 <= 1'b0;
            de_r  <= 1'b0;
            de_r2 <= 1'b0;
        end else begin
            vs_r  <= vs_n;
            vs_r2 <= vs_r;
            de_r  <= de_i;
            de_r2 <= de_r;
        end
    end

    assign vs_edge = vs_r & ~vs_r2;
    assign de_fall = de_r2 & ~de_r;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: leave SYNC at the first frame boundary, then stay ACTIVE.
    always_comb begin
        state_nx = state;
        if ((state == SYNC) && vs_edge) begin
            state_nx = ACTIVE;
        end
    end

    assign frame_end = vs_edge && (state == ACTIVE);

    // Working values after accounting for a line ending this cycle, so a line
    // that ends together with vsync lands in the frame being committed.
    always_comb begin
        line_end = (state == ACTIVE) && de_fall && !drop_line;
        line_nx  = line_cnt;
        wf_nx    = w_first;
        err_nx   = err_w;
        ovf_nx   = ovf_w;
        if (line_end) begin
            if (line_cnt == CNT_MAX) begin
                ovf_nx = 1'b1;
            end else begin
                line_nx = line_cnt + 11'd1;
            end
            if (line_cnt == 11'd0) begin
                wf_nx = pix_cnt;
            end else if (pix_cnt != w_first) begin
                err_nx = 1'b1;
            end
        end
        if ((state == ACTIVE) && de_r && !drop_line && (pix_cnt == CNT_MAX)) begin
            ovf_nx = 1'b1;
        end
    end

    assign frame_empty = (line_nx == 11'd0);

    // Working counters: held clear in SYNC and restarted at every frame boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_cnt   <= 11'd0;
            line_cnt  <= 11'd0;
            w_first   <= 11'd0;
            err_w     <= 1'b0;
            ovf_w     <= 1'b0;
            drop_line <= 1'b0;
        end else if ((state == SYNC) || vs_edge) begin
            pix_cnt   <= 11'd0;
            line_cnt  <= 11'd0;
            w_first   <= 11'd0;
            err_w     <= 1'b0;
            ovf_w     <= 1'b0;
            drop_line <= vs_edge & de_r;
        end else begin
            line_cnt <= line_nx;
            w_first  <= wf_nx;
            err_w    <= err_nx;
            ovf_w    <= ovf_nx;
            if (de_fall) begin
                pix_cnt   <= 11'd0;
                drop_line <= 1'b0;
            end else if (de_r && !drop_line && (pix_cnt != CNT_MAX)) begin
                pix_cnt <= pix_cnt + 11'd1;
            end
        end
    end

`ifdef FRAME_MEAS_STABLE_EN
    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

    logic [10:0] cand_w;
    logic [10:0] cand_h;
    logic [3:0]  match_cnt;
    logic [3:0]  match_nx;

    // Match counter: counts consecutive identical non-empty frames.
    always_comb begin
        match_nx = match_cnt;
        if (frame_end) begin
            if (frame_empty) begin
                match_nx = 4'd0;
            end else if ((match_cnt != 4'd0) && (wf_nx == cand_w) && (line_nx == cand_h)) begin
                match_nx = (match_cnt >= STABLE_N) ? STABLE_N : match_cnt + 4'd1;
            end else begin
                match_nx = 4'd1;
            end
        end
    end

    // Candidate tuple and match counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cand_w    <= 11'd0;
            cand_h    <= 11'd0;
            match_cnt <= 4'd0;
        end else begin
            match_cnt <= match_nx;
            if (frame_end && !frame_empty) begin
                cand_w <= wf_nx;
                cand_h <= line_nx;
            end
        end
    end

    assign do_commit = frame_end && !frame_empty && (match_nx == STABLE_N);
`else
    assign do_commit = frame_end && !frame_empty;
`endif

    // Committed outputs: change only at a committing frame boundary.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            src_width  <= 11'd0;
            src_height <= 11'd0;
            meas_valid <= 1'b0;
            line_err   <= 1'b0;
            ovf        <= 1'b0;
        end else if (do_commit) begin
            src_width  <= wf_nx;
            src_height <= line_nx;
            meas_valid <= 1'b1;
            line_err   <= err_nx;
            ovf        <= ovf_nx;
        end
    end

endmodule
